// File: rtl/mem_req_arbiter.sv
// Arbitrates I$/D$ line-miss requests onto one main-memory port, with round-robin grant,
// one transaction in flight and a programmable delay before each memory request is driven.

module mem_req_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WIDTH  = 128,
    parameter int REQ_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,

    input  logic                  icache_req_valid,
    input  logic [ADDR_WIDTH-1:0] icache_req_addr,

    input  logic                  dcache_req_valid,
    input  logic [ADDR_WIDTH-1:0] dcache_req_addr,
    input  logic                  dcache_req_is_store,
    input  logic [LINE_WIDTH-1:0] dcache_req_data,

    output logic                  mm_req_valid,
    output logic [ADDR_WIDTH-1:0] mm_req_addr,
    output logic                  mm_req_is_store,
    output logic [LINE_WIDTH-1:0] mm_req_data,

    input  logic                  mm_rsp_valid,
    input  logic [LINE_WIDTH-1:0] mm_rsp_data,
    input  logic                  mm_rsp_bus_error,

    output logic                  rsp_valid,
    output logic [LINE_WIDTH-1:0] rsp_data,
    output logic                  rsp_cache_id,
    output logic                  rsp_bus_error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE,
        S_RESP
    } state_t;

    localparam logic SRC_I = 1'b0;
    localparam logic SRC_D = 1'b1;

    localparam int              CNT_W    = (REQ_LATENCY > 1) ? $clog2(REQ_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REQ_LATENCY - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   grant_id_q, grant_id_d;
    logic                   last_grant_q;
    logic                   grant_load;
    logic                   rsp_load;

    logic                   i_pend_q, d_pend_q;
    logic [ADDR_WIDTH-1:0]  i_addr_q, d_addr_q;
    logic                   d_store_q;
    logic [LINE_WIDTH-1:0]  d_data_q;

    logic                   i_clr, d_clr;
    logic                   i_set, d_set;

    // A source's pending flag clears in its RESP cycle; a new pulse in that same
    // cycle re-arms it, so set takes priority over clear.
    assign i_clr = (state_q == S_RESP) && (grant_id_q == SRC_I);
    assign d_clr = (state_q == S_RESP) && (grant_id_q == SRC_D);
    assign i_set = icache_req_valid && (!i_pend_q || i_clr);
    assign d_set = dcache_req_valid && (!d_pend_q || d_clr);

    // NOTE: every sequential block uses non-blocking assignments so all registers
    // sample the pre-edge values of each other, independent of block ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            i_pend_q <= 1'b0;
            i_addr_q <= '0;
        end else if (i_set) begin
            i_pend_q <= 1'b1;
            i_addr_q <= icache_req_addr;
        end else if (i_clr) begin
            i_pend_q <= 1'b0;
        end
    end

    // NOTE: the captured line data is a plain register bank, so it is cleared by
    // reset like the rest of the request info rather than left uninitialised.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            d_pend_q  <= 1'b0;
            d_addr_q  <= '0;
            d_store_q <= 1'b0;
            d_data_q  <= '0;
        end else if (d_set) begin
            d_pend_q  <= 1'b1;
            d_addr_q  <= dcache_req_addr;
            d_store_q <= dcache_req_is_store;
            d_data_q  <= dcache_req_data;
        end else if (d_clr) begin
            d_pend_q  <= 1'b0;
        end
    end

    // NOTE: every output of this block is given a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        grant_id_d      = grant_id_q;
        grant_load      = 1'b0;
        rsp_load        = 1'b0;
        mm_req_valid    = 1'b0;
        mm_req_addr     = '0;
        mm_req_is_store = 1'b0;
        mm_req_data     = '0;
        rsp_valid       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_pend_q || d_pend_q) begin
                    // D$ wins when it is alone, or when both wait and I$ was served last.
                    grant_id_d = d_pend_q && (!i_pend_q || (last_grant_q == SRC_I));
                    grant_load = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_WAIT;
                end
            end

            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                mm_req_valid    = !mm_rsp_valid;
                mm_req_addr     = (grant_id_q == SRC_D) ? d_addr_q : i_addr_q;
                // The I$ never writes back, so its store flag and data are always zero.
                mm_req_is_store = (grant_id_q == SRC_D) && d_store_q;
                mm_req_data     = (grant_id_q == SRC_D) ? d_data_q : '0;
                if (mm_rsp_valid) begin
                    rsp_load = 1'b1;
                    state_d  = S_RESP;
                end
            end

            S_RESP: begin
                rsp_valid = 1'b1;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            grant_id_q   <= SRC_I;
            last_grant_q <= SRC_I;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grant_id_q <= grant_id_d;
            if (grant_load) begin
                last_grant_q <= grant_id_d;
            end
        end
    end

    // Response fields are captured once per transaction and held until the next one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_data      <= '0;
            rsp_bus_error <= 1'b0;
            rsp_cache_id  <= 1'b0;
        end else if (rsp_load) begin
            rsp_data      <= mm_rsp_data;
            rsp_bus_error <= mm_rsp_bus_error;
            rsp_cache_id  <= grant_id_q;
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios plus random traffic, all
// compared every cycle against a transaction-level model of arbitration and timing.

module tb_mem_req_arbiter;

    localparam int AW = 32;
    localparam int LW = 128;
    localparam int L  = 2;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          icache_req_valid = 1'b0;
    logic [AW-1:0] icache_req_addr = '0;
    logic          dcache_req_valid = 1'b0;
    logic [AW-1:0] dcache_req_addr = '0;
    logic          dcache_req_is_store = 1'b0;
    logic [LW-1:0] dcache_req_data = '0;
    logic          mm_req_valid;
    logic [AW-1:0] mm_req_addr;
    logic          mm_req_is_store;
    logic [LW-1:0] mm_req_data;
    logic          mm_rsp_valid = 1'b0;
    logic [LW-1:0] mm_rsp_data = '0;
    logic          mm_rsp_bus_error = 1'b0;
    logic          rsp_valid;
    logic [LW-1:0] rsp_data;
    logic          rsp_cache_id;
    logic          rsp_bus_error;

    mem_req_arbiter #(
        .ADDR_WIDTH (AW),
        .LINE_WIDTH (LW),
        .REQ_LATENCY(L)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .icache_req_valid   (icache_req_valid),
        .icache_req_addr    (icache_req_addr),
        .dcache_req_valid   (dcache_req_valid),
        .dcache_req_addr    (dcache_req_addr),
        .dcache_req_is_store(dcache_req_is_store),
        .dcache_req_data    (dcache_req_data),
        .mm_req_valid       (mm_req_valid),
        .mm_req_addr        (mm_req_addr),
        .mm_req_is_store    (mm_req_is_store),
        .mm_req_data        (mm_req_data),
        .mm_rsp_valid       (mm_rsp_valid),
        .mm_rsp_data        (mm_rsp_data),
        .mm_rsp_bus_error   (mm_rsp_bus_error),
        .rsp_valid          (rsp_valid),
        .rsp_data           (rsp_data),
        .rsp_cache_id       (rsp_cache_id),
        .rsp_bus_error      (rsp_bus_error)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending requests per cache, one active transaction measured
    // by its age in cycles since the grant, and the last response handed back.
    bit            m_i_pend, m_d_pend;
    logic [AW-1:0] m_i_addr, m_d_addr;
    bit            m_d_st;
    logic [LW-1:0] m_d_data;
    bit            m_last_d;
    bit            m_busy;
    bit            m_owner;
    int            m_age;
    bit            m_resp_now;
    logic [LW-1:0] m_rsp_data;
    bit            m_rsp_err, m_rsp_id;

    // Memory responder controls.
    int            rsp_delay   = 1;
    bit            rand_delay  = 1'b0;
    int            err_mode    = 0;    // 0 never, 1 always, 2 random
    bit            data_fixed  = 1'b0;
    logic [LW-1:0] fixed_data  = '0;
    bit            spurious_en = 1'b0;
    bit            force_rsp   = 1'b0;

    // Observed outputs of the most recent cycle.
    bit            obs_mm_valid, obs_mm_st, obs_rsp_valid, obs_rsp_id, obs_rsp_err;
    logic [AW-1:0] obs_mm_addr, last_mm_addr;
    logic [LW-1:0] obs_mm_data, obs_rsp_data;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic bit m_in_issue();
        return m_busy && (m_age >= L);
    endfunction

    task automatic model_reset();
        m_i_pend = 0; m_d_pend = 0; m_i_addr = '0; m_d_addr = '0;
        m_d_st = 0; m_d_data = '0; m_last_d = 0; m_busy = 0; m_owner = 0;
        m_age = 0; m_resp_now = 0; m_rsp_data = '0; m_rsp_err = 0; m_rsp_id = 0;
    endtask

    task automatic compare_outputs();
        bit iss;
        iss = m_in_issue();
        check("mm_req_valid", mm_req_valid, iss && !mm_rsp_valid);
        if (iss) begin
            check("mm_req_addr", mm_req_addr, m_owner ? m_d_addr : m_i_addr);
            check("mm_req_is_store", mm_req_is_store, m_owner && m_d_st);
            check("mm_req_data", mm_req_data, m_owner ? m_d_data : '0);
        end
        check("rsp_valid", rsp_valid, m_resp_now);
        check("rsp_data", rsp_data, m_rsp_data);
        check("rsp_cache_id", rsp_cache_id, m_rsp_id);
        check("rsp_bus_error", rsp_bus_error, m_rsp_err);
    endtask

    task automatic model_step();
        bit i_clr, d_clr, next_resp;
        i_clr     = m_resp_now && !m_owner;
        d_clr     = m_resp_now && m_owner;
        next_resp = 0;
        if (m_in_issue() && mm_rsp_valid) begin
            m_busy     = 0;
            next_resp  = 1;
            m_rsp_data = mm_rsp_data;
            m_rsp_err  = mm_rsp_bus_error;
            m_rsp_id   = m_owner;
        end else if (m_busy) begin
            m_age++;
        end else if (!m_resp_now && (m_i_pend || m_d_pend)) begin
            m_owner  = m_d_pend && (!m_i_pend || !m_last_d);
            m_last_d = m_owner;
            m_busy   = 1;
            m_age    = 0;
        end
        if (icache_req_valid && (!m_i_pend || i_clr)) begin
            m_i_pend = 1;
            m_i_addr = icache_req_addr;
        end else if (i_clr) begin
            m_i_pend = 0;
        end
        if (dcache_req_valid && (!m_d_pend || d_clr)) begin
            m_d_pend = 1;
            m_d_addr = dcache_req_addr;
            m_d_st   = dcache_req_is_store;
            m_d_data = dcache_req_data;
        end else if (d_clr) begin
            m_d_pend = 0;
        end
        m_resp_now = next_resp;
    endtask

    // One clock cycle: drive inputs after the falling edge, answer as memory, check
    // the settled outputs against the model, then advance the model past the edge.
    task automatic cycle(input bit iv, input logic [AW-1:0] ia, input bit dv,
                         input logic [AW-1:0] da, input bit dst, input logic [LW-1:0] dd);
        @(negedge clock);
        icache_req_valid    = iv;
        icache_req_addr     = ia;
        dcache_req_valid    = dv;
        dcache_req_addr     = da;
        dcache_req_is_store = dst;
        dcache_req_data     = dd;
        mm_rsp_valid        = 1'b0;
        mm_rsp_bus_error    = 1'b0;
        mm_rsp_data         = data_fixed ? fixed_data : rand_line();
        if (m_in_issue() && (m_age - L) >= rsp_delay) begin
            mm_rsp_valid     = 1'b1;
            mm_rsp_bus_error = (err_mode == 1) || (err_mode == 2 && $urandom_range(0, 3) == 0);
        end else if (force_rsp || (spurious_en && !m_busy && !m_resp_now && $urandom_range(0, 7) == 0)) begin
            mm_rsp_valid     = 1'b1;
            mm_rsp_bus_error = $urandom_range(0, 1) == 1;
        end
        #1;
        obs_mm_valid  = mm_req_valid;
        obs_mm_addr   = mm_req_addr;
        obs_mm_st     = mm_req_is_store;
        obs_mm_data   = mm_req_data;
        obs_rsp_valid = rsp_valid;
        obs_rsp_id    = rsp_cache_id;
        obs_rsp_err   = rsp_bus_error;
        obs_rsp_data  = rsp_data;
        if (obs_mm_valid) last_mm_addr = obs_mm_addr;
        compare_outputs();
        if (m_in_issue() && mm_rsp_valid && rand_delay) rsp_delay = $urandom_range(0, 3);
        model_step();
    endtask

    task automatic idle_cycle();
        cycle(1'b0, $urandom, 1'b0, $urandom, 1'($urandom_range(0, 1)), rand_line());
    endtask

    task automatic wait_rsp(input string tag, output bit id, output bit err);
        bit got;
        got = 0;
        id  = 0;
        err = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            idle_cycle();
            if (obs_rsp_valid) begin
                got = 1;
                id  = obs_rsp_id;
                err = obs_rsp_err;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no rsp_valid within 60 cycles", tag);
        end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset_n          = 1'b0;
        icache_req_valid = 1'b0;
        dcache_req_valid = 1'b0;
        mm_rsp_valid     = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        bit id, err;
        bit seen;
        int n_issue;

        model_reset();
        repeat (3) @(negedge clock);
        #1;
        check("reset mm_req_valid", mm_req_valid, 0);
        check("reset mm_req_addr", mm_req_addr, 0);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_data", rsp_data, 0);
        check("reset rsp_cache_id", rsp_cache_id, 0);
        check("reset rsp_bus_error", rsp_bus_error, 0);
        @(negedge clock);
        reset_n = 1'b1;
        idle_cycle();

        // D$ load at cycle 0; memory answers in cycle 6.
        rsp_delay  = 2;
        data_fixed = 1'b1;
        fixed_data = 128'hDEAD_BEEF;
        cycle(1'b0, '0, 1'b1, 32'h40, 1'b0, '0);
        check("t1 c0 mm_valid", obs_mm_valid, 0);
        for (int c = 1; c <= 7; c++) begin
            idle_cycle();
            if (c == 3) check("t1 c3 mm_valid", obs_mm_valid, 0);
            if (c == 4) begin
                check("t1 c4 mm_valid", obs_mm_valid, 1);
                check("t1 c4 mm_addr", obs_mm_addr, 32'h40);
                check("t1 c4 mm_store", obs_mm_st, 0);
            end
            if (c == 5) check("t1 c5 mm_valid", obs_mm_valid, 1);
            if (c == 6) begin
                check("t1 c6 mm_valid", obs_mm_valid, 0);
                check("t1 c6 rsp_valid", obs_rsp_valid, 0);
            end
            if (c == 7) begin
                check("t1 c7 rsp_valid", obs_rsp_valid, 1);
                check("t1 c7 rsp_id", obs_rsp_id, 1);
                check("t1 c7 rsp_data", obs_rsp_data, 128'hDEAD_BEEF);
            end
        end
        data_fixed = 1'b0;

        // Simultaneous pulses right after reset: D$ first, then I$.
        apply_reset();
        rsp_delay = 1;
        cycle(1'b1, 32'h1000, 1'b1, 32'h2000, 1'b0, rand_line());
        wait_rsp("t2 first", id, err);
        check("t2 first id", id, 1);
        check("t2 first addr", last_mm_addr, 32'h2000);
        wait_rsp("t2 second", id, err);
        check("t2 second id", id, 0);
        check("t2 second addr", last_mm_addr, 32'h1000);

        // D$ re-pulses in its own RESP cycle while I$ waits: I$ must go next.
        cycle(1'b0, '0, 1'b1, 32'h100, 1'b0, rand_line());
        cycle(1'b1, 32'h200, 1'b0, '0, 1'b0, '0);
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            seen = m_resp_now && m_owner;
            cycle(1'b0, '0, seen, 32'h300, 1'b0, rand_line());
        end
        check("t3 first rsp_valid", obs_rsp_valid, 1);
        check("t3 first id", obs_rsp_id, 1);
        wait_rsp("t3 second", id, err);
        check("t3 second id", id, 0);
        check("t3 second addr", last_mm_addr, 32'h200);
        wait_rsp("t3 third", id, err);
        check("t3 third id", id, 1);
        check("t3 third addr", last_mm_addr, 32'h300);

        // D$ store held stable across a three-cycle ISSUE.
        rsp_delay = 3;
        n_issue   = 0;
        seen      = 0;
        cycle(1'b0, '0, 1'b1, 32'h80, 1'b1, 128'h1234);
        for (int k = 0; k < 40 && !seen; k++) begin
            idle_cycle();
            if (obs_mm_valid) begin
                n_issue++;
                check("t4 mm_store", obs_mm_st, 1);
                check("t4 mm_data", obs_mm_data, 128'h1234);
                check("t4 mm_addr", obs_mm_addr, 32'h80);
            end
            if (obs_rsp_valid) begin
                seen = 1;
                check("t4 rsp_id", obs_rsp_id, 1);
            end
        end
        check("t4 issue cycles", n_issue, 3);

        // Bus error reported to I$, then cleared by the next transaction.
        rsp_delay = 1;
        err_mode  = 1;
        cycle(1'b1, 32'hFFFF_FFF0, 1'b0, '0, 1'b0, '0);
        wait_rsp("t5 err", id, err);
        check("t5 err id", id, 0);
        check("t5 err flag", err, 1);
        check("t5 err addr", last_mm_addr, 32'hFFFF_FFF0);
        err_mode = 0;
        cycle(1'b0, '0, 1'b1, 32'h40, 1'b0, '0);
        wait_rsp("t5 ok", id, err);
        check("t5 ok id", id, 1);
        check("t5 ok flag", err, 0);

        // Reset during ISSUE, then a late response arriving in IDLE.
        rsp_delay = 1000;
        seen      = 0;
        cycle(1'b1, 32'h500, 1'b0, '0, 1'b0, '0);
        for (int k = 0; k < 20 && !seen; k++) begin
            idle_cycle();
            seen = obs_mm_valid;
        end
        check("t6 reached issue", seen, 1);
        reset_n = 1'b0;
        #1;
        check("t6 mm_valid drop", mm_req_valid, 0);
        check("t6 rsp_valid in reset", rsp_valid, 0);
        model_reset();
        repeat (2) @(negedge clock);
        reset_n   = 1'b1;
        force_rsp = 1'b1;
        idle_cycle();
        force_rsp = 1'b0;
        seen      = 0;
        for (int k = 0; k < 6; k++) begin
            idle_cycle();
            seen = seen || obs_rsp_valid || obs_mm_valid;
        end
        check("t6 quiet after reset", seen, 0);

        // Random traffic against the model.
        rsp_delay   = 1;
        rand_delay  = 1'b1;
        err_mode    = 2;
        spurious_en = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            cycle($urandom_range(0, 5) == 0, $urandom,
                  $urandom_range(0, 4) == 0, $urandom,
                  1'($urandom_range(0, 1)), rand_line());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Arbitrates cache-line miss requests from the I$ and D$ onto the single main-memory request port.
- Returns each memory response to the cache that requested it, tagged with a cache id (0 = I$, 1 = D$).
- Sits between core_top's icache/dcache miss interfaces and the main-memory model.
- Adds a programmable request latency and enforces one outstanding memory transaction at a time.

Parameters:
- ADDR_WIDTH, 32, width of the line address.
- LINE_WIDTH, 128, width of a cache line in bits.
- REQ_LATENCY, 2, cycles spent in WAIT before the memory request is driven; must be at least 1.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- icache_req_valid  in  1  single-cycle I$ miss request pulse.
- icache_req_addr  in  ADDR_WIDTH  I$ line address.
- dcache_req_valid  in  1  single-cycle D$ miss request pulse.
- dcache_req_addr  in  ADDR_WIDTH  D$ line address.
- dcache_req_is_store  in  1  1 = D$ write-back, 0 = D$ load.
- dcache_req_data  in  LINE_WIDTH  write-back data.
- mm_req_valid  out  1  request to memory, level signal.
- mm_req_addr  out  ADDR_WIDTH  address of the granted request.
- mm_req_is_store  out  1  store flag of the granted request.
- mm_req_data  out  LINE_WIDTH  store data of the granted request.
- mm_rsp_valid  in  1  memory response pulse.
- mm_rsp_data  in  LINE_WIDTH  memory read data.
- mm_rsp_bus_error  in  1  address error, qualified by mm_rsp_valid.
- rsp_valid  out  1  response pulse to the caches.
- rsp_data  out  LINE_WIDTH  response line.
- rsp_cache_id  out  1  0 = I$, 1 = D$.
- rsp_bus_error  out  1  bus error, qualified by rsp_valid.

Behaviour:
- Reset (reset_n = 0, asynchronous):
  - All outputs are 0; state is IDLE.
  - Pending flags, captured request info, latency counter and last_grant are cleared; last_grant resets to I$.
  - Reset asserted mid-transaction drops mm_req_valid immediately and discards the in-flight request. A late mm_rsp_valid arriving in IDLE is ignored.
- Capture:
  - A *_req_valid pulse sets that source's pending flag and registers its address, store flag and data on the same edge.
  - Each source has at most one outstanding request. A pulse while that source is already pending is ignored and the original request is kept.
  - A pulse in the same cycle as that source's RESP cycle is captured, because set wins over clear.
  - The I$ store flag is forced to 0.
- FSM:
  - IDLE -> WAIT when any flag is pending.
    - Grant goes to D$ if only D$ is pending, or to I$ if only I$ is pending.
    - If both are pending, grant goes to the source not recorded in last_grant (round-robin).
    - The winner is latched into grant_id and last_grant, and the counter is cleared to 0.
  - WAIT: the counter increments each cycle; when the counter equals REQ_LATENCY-1 the FSM moves to ISSUE.
  - ISSUE:
    - mm_req_valid = !mm_rsp_valid. The mm_req_* fields are driven from the granted source's captured info and held stable for the whole ISSUE state.
    - On mm_rsp_valid the FSM moves to RESP and registers rsp_data <= mm_rsp_data, rsp_bus_error <= mm_rsp_bus_error and rsp_cache_id <= grant_id.
  - RESP:
    - rsp_valid = 1 for exactly one cycle and the granted source's pending flag is cleared.
    - The FSM moves to IDLE, which can grant again on the next edge.
- Latency: from request pulse at cycle 0 to mm_req_valid asserted is 2 + REQ_LATENCY cycles. rsp_valid comes one cycle after mm_rsp_valid.
- Stores: a memory response still produces rsp_valid to the D$. rsp_data is whatever memory returns and is don't-care for the D$.
- rsp_data and rsp_bus_error hold their last values outside RESP.
- A grant is never pre-empted. The other source waits in pending until the FSM returns to IDLE.

Test Plan:
1. D$ load only, REQ_LATENCY = 2, addr 0x40 at cycle 0; memory returns 0xDEAD_BEEF in cycle 6 -> mm_req_valid high cycles 4-5 with addr 0x40 and is_store 0; rsp_valid at cycle 7 with cache_id 1 and data 0xDEAD_BEEF.
2. I$ and D$ pulse in the same cycle just after reset -> D$ served first (last_grant reset = I$), then I$; two rsp_valid pulses with cache_id 1 then 0.
3. Back-to-back D$ requests while I$ is pending (D$ re-pulses in its RESP cycle) -> I$ is granted before the second D$ request; the second D$ response follows, so no starvation.
4. D$ store to 0x80 with data 0x1234 -> mm_req_is_store 1 and mm_req_data 0x1234 stable for all of ISSUE; rsp_valid with cache_id 1.
5. mm_rsp_bus_error = 1 with the response for I$ addr 0xFFFF_FFF0 -> rsp_valid = 1, rsp_bus_error = 1, cache_id 0; next transaction reports rsp_bus_error 0.
6. reset_n pulled low during ISSUE -> mm_req_valid drops within the cycle; after release the FSM is IDLE, no rsp_valid is produced, and a late mm_rsp_valid is ignored.
